// File: rtl/rv_pkg.sv
// Shared RV32 definitions: base opcodes, the canonical NOP and the fetch FSM states.
package rv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_VALID,
        FS_DRAIN,
        FS_HALT_RST
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, single-entry decode buffer,
// redirect handling that drains an in-flight request before refetching.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  SEQ_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  redir_tgt;

    assign redir_tgt = align_pc(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_HALT_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            target_q   <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        target_d   = target_q;
        unique case (state_q)
            FS_HALT_RST: state_d = FS_REQ;
            FS_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_d = redir_tgt;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = fetch_pc_q;
                        state_d = FS_VALID;
                    end
                end else if (redirect) begin
                    target_d = redir_tgt;
                    state_d  = FS_DRAIN;
                end
            end
            FS_VALID: begin
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                    state_d    = FS_REQ;
                end else if (instr_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'(SEQ_STEP);
                    state_d    = FS_REQ;
                end
            end
            FS_DRAIN: begin
                // The in-flight address stays on the bus; a redirect arriving with
                // the ack is newer than the latched target and wins.
                if (redirect) begin
                    target_d = redir_tgt;
                end
                if (imem_ack) begin
                    fetch_pc_d = redirect ? redir_tgt : target_q;
                    state_d    = FS_REQ;
                end
            end
            default: state_d = FS_HALT_RST;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            FS_REQ, FS_DRAIN: imem_req    = 1'b1;
            FS_VALID:         instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    assign imem_addr = fetch_pc_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign opcode    = instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model and a
// memory whose contents are a fixed function of the address.
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, instr, pc, redirect_pc;
    logic [6:0]  opcode;

    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2;
    logic [6:0]  opcode2;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case ((a >> 2) % 9)
            0: op = OP_RTYPE;
            1: op = OP_ITYPE;
            2: op = OP_LOAD;
            3: op = OP_STORE;
            4: op = OP_BRANCH;
            5: op = OP_LUI;
            6: op = OP_AUIPC;
            7: op = OP_JAL;
            default: op = OP_JALR;
        endcase
        return {a[26:2], op};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);
    assign ack2       = req2 & ~rst;

    fetch_unit #(.RESET_PC(RST_PC), .SEQ_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc(pc),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(RST_PC2), .SEQ_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr(instr2), .opcode(opcode2), .pc(pc2),
        .instr_ready(1'b1), .redirect(1'b0), .redirect_pc(32'h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding request, whether its data will be
    // dropped, and the instruction currently offered to decode.
    logic        m_start, m_req, m_valid, m_discard;
    logic [31:0] m_addr, m_next, m_instr, m_pc, m_tgt;
    assign m_tgt = redirect_pc & 32'hFFFF_FFFC;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_start <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0; m_discard <= 1'b0;
            m_addr <= RST_PC; m_next <= RST_PC; m_instr <= NOP; m_pc <= RST_PC;
        end else if (m_start) begin
            m_start <= 1'b0;
            m_req   <= 1'b1;
        end else if (m_req) begin
            if (imem_ack) begin
                if (m_discard || redirect) begin
                    m_addr    <= redirect ? m_tgt : m_next;
                    m_discard <= 1'b0;
                end else begin
                    m_instr <= mem_word(m_addr);
                    m_pc    <= m_addr;
                    m_valid <= 1'b1;
                    m_req   <= 1'b0;
                end
            end else if (redirect) begin
                m_discard <= 1'b1;
                m_next    <= m_tgt;
            end
        end else if (m_valid) begin
            if (redirect) begin
                m_addr <= m_tgt; m_valid <= 1'b0; m_req <= 1'b1;
            end else if (instr_ready) begin
                m_addr <= m_addr + 32'd4; m_valid <= 1'b0; m_req <= 1'b1;
            end
        end
    end

    logic [31:0] pc_log[$];
    logic [6:0]  op_log[$];
    logic [31:0] a2_log[$];
    logic        prev_v = 1'b0;
    logic        drain_watch = 1'b0;
    int          drain_valids = 0;

    always @(negedge clk) begin
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req && imem_req) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("instr", instr, m_instr);
        chk("pc", pc, m_pc);
        chk("opcode", {25'b0, opcode}, {25'b0, m_instr[6:0]});
        if (instr_valid && !prev_v) begin
            pc_log.push_back(pc);
            op_log.push_back(opcode);
        end
        if (drain_watch && instr_valid) drain_valids <= drain_valids + 1;
        prev_v <= instr_valid;
    end

    always @(posedge clk) begin
        if (!rst && req2 && ack2) a2_log.push_back(addr2);
    end

    int D   = 1;
    int cnt = 0;

    task automatic tick();
        @(negedge clk);
        #1;
        if (m_req && !rst) begin
            if (cnt >= D) begin imem_ack = 1'b1; cnt = 0; end
            else begin imem_ack = 1'b0; cnt++; end
        end else begin
            imem_ack = 1'b0;
            cnt = 0;
        end
    endtask

    task automatic wait_mvalid();
        int n = 0;
        while (!m_valid && n < 50) begin tick(); n++; end
        chk("wait_valid", {31'b0, m_valid}, 32'd1);
    endtask

    initial begin
        int n;
        instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        // Stray ack during reset must be ignored.
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc",    pc, RST_PC);
        rst = 1'b0;
        imem_ack = 1'b0;

        n = 0;
        while (pc_log.size() < 4 && n < 100) begin tick(); n++; end
        instr_ready = 1'b0;
        chk("seq_count", pc_log.size(), 32'd4);
        if (pc_log.size() >= 4) begin
            chk("seq_pc0", pc_log[0], 32'h0);
            chk("seq_pc1", pc_log[1], 32'h4);
            chk("seq_pc2", pc_log[2], 32'h8);
            chk("seq_pc3", pc_log[3], 32'hC);
            chk("seq_op0", {25'b0, op_log[0]}, {25'b0, 7'b0110011});
            chk("seq_op1", {25'b0, op_log[1]}, {25'b0, 7'b0010011});
            chk("seq_op2", {25'b0, op_log[2]}, {25'b0, 7'b0000011});
            chk("seq_op3", {25'b0, op_log[3]}, {25'b0, 7'b0100011});
        end

        repeat (3) tick();
        chk("stall_pc",    pc, 32'hC);
        chk("stall_instr", instr, mem_word(32'hC));
        chk("stall_req",   {31'b0, imem_req},    32'd0);
        chk("stall_valid", {31'b0, instr_valid}, 32'd1);

        // Redirect beats ready in the same cycle.
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        chk("redir_addr",  imem_addr, 32'h0000_0100);
        chk("redir_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_req",   {31'b0, imem_req},    32'd1);

        wait_mvalid();
        chk("redir_pc", pc, 32'h0000_0100);
        D = 3;
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        drain_watch = 1'b1;
        chk("drain_start_addr", imem_addr, 32'h8);
        tick();
        redirect = 1'b0;
        n = 0;
        while (n < 10) begin
            chk("drain_hold_addr", imem_addr, 32'h8);
            if (imem_ack) break;
            tick();
            n++;
        end
        tick();
        chk("drain_new_addr", imem_addr, 32'h40);
        chk("drain_new_req",  {31'b0, imem_req}, 32'd1);
        chk("drain_no_valid", drain_valids, 32'd0);
        drain_watch = 1'b0;
        D = 1;

        wait_mvalid();
        chk("drain_pc", pc, 32'h40);
        D = 0;
        tick();
        chk("ack0_ack", {31'b0, imem_ack}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        chk("ack0_addr",  imem_addr, 32'h0000_0200);
        chk("ack0_valid", {31'b0, instr_valid}, 32'd0);
        wait_mvalid();
        chk("ack0_pc", pc, 32'h0000_0200);

        D = 3;
        tick();
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req",   {31'b0, imem_req},    32'd0);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0000_0013);
        chk("arst_pc",    pc, RST_PC);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        D = 1;
        tick();
        chk("arst_req_after",  {31'b0, imem_req}, 32'd1);
        chk("arst_addr_after", imem_addr, RST_PC);
        repeat (10) tick();

        chk("wrap_count", {31'b0, a2_log.size() >= 3}, 32'd1);
        if (a2_log.size() >= 3) begin
            chk("wrap_a0", a2_log[0], 32'hFFFF_FFF8);
            chk("wrap_a1", a2_log[1], 32'hFFFF_FFFC);
            chk("wrap_a2", a2_log[2], 32'h0000_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
